out_port_serializer: RTL and testbench
======================================

# out_port_serializer

Output-side peripheral at the far end of the CPU's out port. On each out-port write strobe it captures one 32-bit word into a small FIFO and transmits queued words on a single serial line. Each frame is one start bit, 32 data bits LSB-first, then one stop bit. This decouples the datapath's single-cycle out-port write from a slow external consumer, and gives the CPU full/empty status for polling.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- BAUD_DIV, 8: clock cycles per serial bit; ≥2.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- clear  in  1  reset; synchronous, active-high.
- out_port_enable  in  1  write strobe; word is captured on the edge where this is 1.
- out_port_data  in  32  word to enqueue.
- tx  out  1  serial line; idles high.
- busy  out  1  a frame is in progress (state ≠ IDLE).
- empty  out  1  FIFO holds 0 words.
- full  out  1  FIFO holds DEPTH words.
- overflow  out  1  sticky; a write was dropped because the FIFO was full.

## Operation
- FIFO:
  - Circular buffer with wr_ptr, rd_ptr and count, all log2(DEPTH)+1 bits wide.
  - Pointers wrap modulo DEPTH.
  - empty = (count==0). full = (count==DEPTH).
- Write:
  - Accepted when out_port_enable=1 and full=0 as sampled that cycle.
  - On acceptance, the data is stored at wr_ptr and wr_ptr increments.
  - A write while full=1 is dropped and sets overflow. This holds even if a pop occurs in the same cycle.
- Pop: occurs only on the IDLE→START or STOP→START transition. The popped word loads a 32-bit shift register.
- Simultaneous accepted write and pop: count is unchanged; both pointers advance.
- Counters:
  - baud_cnt runs 0..BAUD_DIV-1 within each bit period. bit_done = (baud_cnt==BAUD_DIV-1).
  - bit_cnt runs 0..31 in DATA.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If empty=0, pop, set baud_cnt=0, go to START.
  - START: tx=0. On bit_done, set bit_cnt=0 and go to DATA.
  - DATA: tx=shift[0].
    - On bit_done, shift right by 1 and increment bit_cnt.
    - If bit_cnt==31, go to STOP instead.
  - STOP: tx=1. On bit_done:
    - If empty=0, pop and go to START; back-to-back frames have no extra idle bit.
    - Otherwise go to IDLE.
- tx is driven from a register, so there is no combinational path from inputs to tx.
- overflow clears only on clear.
- clear mid-frame:
  - Next edge: state=IDLE, tx=1, FIFO emptied (pointers and count = 0), overflow=0.
  - The partial frame is abandoned.
  - A write on the same edge as clear is ignored.

## Timing
- Reset values: tx=1, busy=0, empty=1, full=0, overflow=0.
- Write latency: a write accepted at edge E updates empty/full/count visible after E.
- Start latency:
  - From IDLE with an empty FIFO, a write accepted at edge E is popped at edge E+1.
  - tx goes low after E+1.
  - busy rises after E+1; empty returns to 1 after E+1 if no other word is queued.
- Frame length: exactly 34·BAUD_DIV cycles from tx falling to the end of the stop bit.
- Every bit, including start and stop, is held exactly BAUD_DIV cycles.
- Back-to-back frames: the next start bit follows the stop bit with zero gap.
- Throughput: at most one word per 34·BAUD_DIV cycles. The CPU must poll full, or accept drops flagged by overflow.
- Status outputs (empty, full, busy, overflow) are registered, or derived combinationally from registered state only.

## Test plan
All scenarios use BAUD_DIV=4, DEPTH=4.

1. Reset:
   - Stimulus: assert clear for 2 cycles.
   - Required: tx=1, busy=0, empty=1, full=0, overflow=0.
2. Single word:
   - Stimulus: write 32'hA5A5_0F01.
   - Required:
     - tx falls 2 edges after the strobe.
     - Sampling mid-bit every 4 cycles yields start=0, data bits 1,0,0,0,0,0,0,0,1,1,1,1,0,0,0,0,1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1, stop=1.
     - busy drops after 136 cycles.
3. Back-to-back:
   - Stimulus: write 32'h0000_0001 and 32'h8000_0000 on consecutive cycles.
   - Required:
     - Two frames totalling 272 cycles.
     - The second start bit follows the first stop bit with no idle cycles.
     - The second frame has data bit 31 = 1 and all other data bits 0.
4. Full and overflow:
   - Stimulus: write 6 words (1..6) on consecutive cycles starting from IDLE.
   - Required:
     - Word 1 is popped.
     - Words 2..5 fill the FIFO; full=1.
     - Word 6 is dropped; overflow=1.
     - Transmitted order is 1,2,3,4,5.
     - overflow stays 1 until clear.
5. Pointer wrap:
   - Stimulus: stream 10 words, writing each only when full=0.
   - Required: all 10 words are transmitted in order, intact, and overflow stays 0.
6. Reset mid-frame:
   - Stimulus: assert clear during DATA bit 10 with 2 words queued.
   - Required:
     - Next cycle: tx=1, busy=0, empty=1.
     - No further frames are sent.
     - A subsequent write of 32'h1 transmits correctly.

Source files
------------

// File: rtl/out_port_serializer.sv
// Out-port FIFO plus serial transmitter: each captured word is sent as
// start(0), 32 data bits LSB-first, stop(1), with back-to-back frames when queued.
module out_port_serializer #(
    parameter int DEPTH    = 4,
    parameter int BAUD_DIV = 8
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        out_port_enable,
    input  logic [31:0] out_port_data,
    output logic        tx,
    output logic        busy,
    output logic        empty,
    output logic        full,
    output logic        overflow
);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int AW = PW - 1;
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [PW-1:0] DEPTH_C   = PW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, count;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [4:0]    bit_cnt, bit_n;
    logic [31:0]   shift, shift_n;
    logic          tx_n, pop, wr_acc, bit_done;

    // Pointers never reach DEPTH, so their top bit carries no information.
    logic unused_ptr_msb;
    assign unused_ptr_msb = wr_ptr[PW-1] ^ rd_ptr[PW-1];

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign busy     = (state != IDLE);
    assign wr_acc   = out_port_enable && !full;
    assign bit_done = (baud_cnt == BAUD_LAST);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    baud_n  = '0;
                    shift_n = mem[rd_ptr[AW-1:0]];
                    state_n = START;
                end
            end
            START: begin
                if (bit_done) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_n = '0;
                    if (bit_cnt == 5'd31) begin
                        state_n = STOP;
                    end else begin
                        shift_n = shift >> 1;
                        bit_n   = bit_cnt + 5'd1;
                    end
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    baud_n = '0;
                    // Chain straight into the next start bit when work is queued.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr[AW-1:0]];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // tx is registered from next-state values, so it lines up with state.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (wr_acc && !clear) mem[wr_ptr[AW-1:0]] <= out_port_data;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            tx       <= tx_n;
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)    rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_acc, pop})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
            if (out_port_enable && full) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_out_port_serializer.sv
// Directed bench for out_port_serializer with BAUD_DIV=4, DEPTH=4.
module tb_out_port_serializer;
    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        out_port_enable = 1'b0;
    logic [31:0] out_port_data = '0;
    logic        tx, busy, empty, full, overflow;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int last_wr = 0;

    out_port_serializer #(.DEPTH(4), .BAUD_DIV(4)) dut (
        .clock(clock), .clear(clear), .out_port_enable(out_port_enable),
        .out_port_data(out_port_data), .tx(tx), .busy(busy), .empty(empty),
        .full(full), .overflow(overflow)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr_word(input logic [31:0] d);
        out_port_enable = 1'b1;
        out_port_data   = d;
        tick();
        out_port_enable = 1'b0;
        last_wr = cyc;
    endtask

    // Waits for a falling tx, then samples each bit at its middle.
    task automatic recv(output logic [31:0] w, output int fall, output logic st,
                        output logic sp, output logic to);
        int n;
        n = 0; w = '0; to = 1'b0; st = 1'b1; sp = 1'b0; fall = 0;
        while (tx !== 1'b0 && n < 3000) begin tick(); n++; end
        if (tx !== 1'b0) begin to = 1'b1; fall = cyc; return; end
        fall = cyc;
        tick(); tick();
        st = tx;
        for (int i = 0; i < 32; i++) begin
            repeat (4) tick();
            w[i] = tx;
        end
        repeat (4) tick();
        sp = tx;
    endtask

    task automatic wait_idle(output int at);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin tick(); n++; end
        at = cyc;
    endtask

    task automatic test_reset();
        clear = 1'b1; tick(); tick(); clear = 1'b0;
        n_vec++; if (tx !== 1'b1)       begin n_err++; $display("FAIL reset_tx got %b exp 1", tx); end
        n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_vec++; if (empty !== 1'b1)    begin n_err++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_vec++; if (full !== 1'b0)     begin n_err++; $display("FAIL reset_full got %b exp 0", full); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    endtask

    task automatic test_single();
        logic [31:0] w; int f, idle_at; logic st, sp, to;
        wr_word(32'hA5A5_0F01);
        recv(w, f, st, sp, to);
        n_vec++; if (to !== 1'b0)        begin n_err++; $display("FAIL single_timeout got %b exp 0", to); end
        n_vec++; if (f !== last_wr + 1)  begin n_err++; $display("FAIL single_latency got %0d exp %0d", f, last_wr + 1); end
        n_vec++; if (st !== 1'b0)        begin n_err++; $display("FAIL single_start got %b exp 0", st); end
        n_vec++; if (w !== 32'hA5A5_0F01) begin n_err++; $display("FAIL single_data got %h exp a5a50f01", w); end
        n_vec++; if (sp !== 1'b1)        begin n_err++; $display("FAIL single_stop got %b exp 1", sp); end
        wait_idle(idle_at);
        n_vec++; if (idle_at !== f + 136) begin n_err++; $display("FAIL single_len got %0d exp %0d", idle_at - f, 136); end
        n_vec++; if (empty !== 1'b1)     begin n_err++; $display("FAIL single_empty got %b exp 1", empty); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w1, w2; int f1, f2, idle_at; logic st1, sp1, to1, st2, sp2, to2;
        wr_word(32'h0000_0001);
        wr_word(32'h8000_0000);
        recv(w1, f1, st1, sp1, to1);
        recv(w2, f2, st2, sp2, to2);
        n_vec++; if (to1 !== 1'b0 || to2 !== 1'b0) begin n_err++; $display("FAIL b2b_timeout got %b%b exp 00", to1, to2); end
        n_vec++; if (w1 !== 32'h0000_0001) begin n_err++; $display("FAIL b2b_word1 got %h exp 00000001", w1); end
        n_vec++; if (w2 !== 32'h8000_0000) begin n_err++; $display("FAIL b2b_word2 got %h exp 80000000", w2); end
        n_vec++; if (f2 !== f1 + 136)      begin n_err++; $display("FAIL b2b_gap got %0d exp 136", f2 - f1); end
        n_vec++; if (sp1 !== 1'b1 || sp2 !== 1'b1) begin n_err++; $display("FAIL b2b_stop got %b%b exp 11", sp1, sp2); end
        wait_idle(idle_at);
        n_vec++; if (idle_at !== f1 + 272) begin n_err++; $display("FAIL b2b_total got %0d exp 272", idle_at - f1); end
    endtask

    task automatic test_full_overflow();
        logic [31:0] got [5]; logic tos [5]; int idle_at; logic fl4, ov4, fl5, ov5;
        fl4 = 1'b0; ov4 = 1'b0; fl5 = 1'b0; ov5 = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    wr_word(32'(i));
                    if (i == 5) begin fl4 = full; ov4 = overflow; end
                    if (i == 6) begin fl5 = full; ov5 = overflow; end
                end
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    logic [31:0] w; int f; logic st, sp, to;
                    recv(w, f, st, sp, to);
                    got[k] = w; tos[k] = to;
                end
            end
        join
        n_vec++; if (fl4 !== 1'b1 || ov4 !== 1'b0) begin n_err++; $display("FAIL fifo_full got full=%b ovf=%b exp 1 0", fl4, ov4); end
        n_vec++; if (fl5 !== 1'b1 || ov5 !== 1'b1) begin n_err++; $display("FAIL fifo_drop got full=%b ovf=%b exp 1 1", fl5, ov5); end
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (tos[k] !== 1'b0 || got[k] !== 32'(k + 1)) begin
                n_err++; $display("FAIL fifo_order[%0d] got %h to=%b exp %h", k, got[k], tos[k], 32'(k + 1));
            end
        end
        wait_idle(idle_at);
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
        n_vec++; if (empty !== 1'b1)    begin n_err++; $display("FAIL fifo_drained got %b exp 1", empty); end
        clear = 1'b1; tick(); clear = 1'b0;
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    endtask

    task automatic test_wrap();
        logic [31:0] got [10]; logic tos [10]; int idle_at;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    int n;
                    n = 0;
                    while (full !== 1'b0 && n < 3000) begin tick(); n++; end
                    wr_word(32'hDEAD_BEEF ^ (32'(i) * 32'h1111_1111));
                end
            end
            begin
                for (int k = 0; k < 10; k++) begin
                    logic [31:0] w; int f; logic st, sp, to;
                    recv(w, f, st, sp, to);
                    got[k] = w; tos[k] = to;
                end
            end
        join
        for (int k = 0; k < 10; k++) begin
            n_vec++;
            if (tos[k] !== 1'b0 || got[k] !== (32'hDEAD_BEEF ^ (32'(k) * 32'h1111_1111))) begin
                n_err++; $display("FAIL wrap[%0d] got %h to=%b exp %h", k, got[k], tos[k],
                                  32'hDEAD_BEEF ^ (32'(k) * 32'h1111_1111));
            end
        end
        wait_idle(idle_at);
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL wrap_overflow got %b exp 0", overflow); end
    endtask

    task automatic test_clear_mid_frame();
        int f, n_low; logic [31:0] w; int ff; logic st, sp, to;
        wr_word(32'h1234_5678);
        f = last_wr + 1;
        wr_word(32'h2222_2222);
        wr_word(32'h3333_3333);
        while (cyc < f + 45) tick();
        n_vec++; if (busy !== 1'b1 || empty !== 1'b0) begin n_err++; $display("FAIL mid_pre got busy=%b empty=%b exp 1 0", busy, empty); end
        clear = 1'b1; tick(); clear = 1'b0;
        n_vec++; if (tx !== 1'b1)    begin n_err++; $display("FAIL mid_tx got %b exp 1", tx); end
        n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL mid_busy got %b exp 0", busy); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL mid_empty got %b exp 1", empty); end
        n_low = 0;
        repeat (300) begin tick(); if (tx !== 1'b1) n_low++; end
        n_vec++; if (n_low !== 0) begin n_err++; $display("FAIL mid_quiet got %0d low cycles exp 0", n_low); end
        wr_word(32'h0000_0001);
        recv(w, ff, st, sp, to);
        n_vec++; if (to !== 1'b0 || w !== 32'h0000_0001 || sp !== 1'b1) begin
            n_err++; $display("FAIL mid_after got %h stop=%b to=%b exp 00000001 1 0", w, sp, to);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_overflow();
        test_wrap();
        test_clear_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
